vc_status_ctrl: RTL and testbench

Per-output-port virtual-channel status controller for the router's upstream (sending) side. It tracks which downstream VCs are free, busy, or draining, and grants free VCs to requesting packets through a request/grant handshake. It keeps a per-VC credit count of downstream buffer space and raises per-VC send permission. The busy/free state it holds is the one the downstream input stage sets and clears per VC, seen from the sending end.

---
 rtl/vc_status_ctrl_if.sv | 36 +++
 rtl/vc_status_ctrl.sv | 155 +++++++++++++++
 tb/tb_vc_status_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vc_status_ctrl_if.sv
// vc_status_ctrl_if: handshake and status bundle between a port's sender logic and its VC status controller.
// Latency: none (wires only).
// Backpressure: none here; the controller refuses flits through send_ok and grants VCs through alloc_req/alloc_gnt.
//
// Signals:
//   alloc_req / alloc_gnt / alloc_vc     VC allocation request and one-cycle grant with the granted index
//   flit_valid / flit_vc / flit_tail     flit sent downstream this cycle
//   credit_valid / credit_vc             credit returned by the downstream buffer
//   vc_busy / send_ok / err              per-VC status and protocol-error pulse
// master = sender/downstream side (drives requests, flits, credits); slave = the controller.
interface vc_status_ctrl_if #(
   parameter int NUM_VC   = 4,
   parameter int VC_IDX_W = 2
);
   logic                alloc_req;
   logic                alloc_gnt;
   logic [VC_IDX_W-1:0] alloc_vc;
   logic                flit_valid;
   logic [VC_IDX_W-1:0] flit_vc;
   logic                flit_tail;
   logic                credit_valid;
   logic [VC_IDX_W-1:0] credit_vc;
   logic [NUM_VC-1:0]   vc_busy;
   logic [NUM_VC-1:0]   send_ok;
   logic                err;

   modport master (
      output alloc_req, flit_valid, flit_vc, flit_tail, credit_valid, credit_vc,
      input  alloc_gnt, alloc_vc, vc_busy, send_ok, err
   );

   modport slave (
      input  alloc_req, flit_valid, flit_vc, flit_tail, credit_valid, credit_vc,
      output alloc_gnt, alloc_vc, vc_busy, send_ok, err
   );
endinterface

// File: rtl/vc_status_ctrl.sv
// vc_status_ctrl: per-output-port tracker of downstream VC state (FREE/ACTIVE/DRAIN) and credits, with VC allocation.
// Latency: grant one cycle after the sampling edge; vc_busy/send_ok are decodes of registered state.
// Backpressure: alloc_req waits while no VC is FREE; flits are accepted only when send_ok[flit_vc] is set.
//
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous active-low reset
//   bus    vc_status_ctrl_if.slave (allocation handshake, flit and credit events, status outputs)
// Optional feature: define VC_ERR_CHECK_EN to get a one-cycle err pulse after a dropped flit or an
// ignored credit; otherwise err is tied to 0 and drop/ignore behaviour is the same.
module vc_status_ctrl #(
   parameter int NUM_VC    = 4,
   parameter int VC_IDX_W  = 2,
   parameter int BUF_DEPTH = 4,
   parameter int CNT_W     = 3
) (
   input  logic            clk,
   input  logic            reset,
   vc_status_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      VC_FREE   = 2'd0,
      VC_ACTIVE = 2'd1,
      VC_DRAIN  = 2'd2
   } vc_state_t;

   localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(BUF_DEPTH);

   vc_state_t           state_q [NUM_VC];
   vc_state_t           state_d [NUM_VC];
   logic [CNT_W-1:0]    cred_q  [NUM_VC];
   logic [CNT_W-1:0]    cred_d  [NUM_VC];
   logic                gnt_q;
   logic                gnt_d;
   logic [VC_IDX_W-1:0] gnt_vc_q;
   logic [VC_IDX_W-1:0] gnt_vc_d;
   logic                err_q;
   logic                err_d;

   logic [NUM_VC-1:0]   free_w;
   logic [NUM_VC-1:0]   send_ok_w;
   logic                any_free;
   logic [VC_IDX_W-1:0] grant_idx;
   logic                grant_now;
   logic                flit_acc;
   logic                cred_acc;

   // Status decodes from registered state only: no input reaches vc_busy/send_ok combinationally.
   always_comb begin
      free_w    = '0;
      send_ok_w = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         free_w[v]    = (state_q[v] == VC_FREE);
         send_ok_w[v] = (state_q[v] == VC_ACTIVE) && (cred_q[v] != '0);
      end
   end

   // Event qualification. A credit is judged against the credit held before this edge, so a credit
   // arriving at BUF_DEPTH is ignored even if a flit on the same VC is accepted in the same cycle.
   always_comb begin
      flit_acc = bus.flit_valid & send_ok_w[bus.flit_vc];
      cred_acc = bus.credit_valid & (cred_q[bus.credit_vc] != CRED_MAX);
   end

   // Lowest-index FREE VC. Uses pre-edge state, so a VC freed on this edge is grantable one edge later.
   always_comb begin
      grant_idx = '0;
      any_free  = 1'b0;
      for (int v = NUM_VC - 1; v >= 0; v--) begin
         if (free_w[v]) begin
            grant_idx = VC_IDX_W'(v);
            any_free  = 1'b1;
         end
      end
      // A request seen while the grant pulse is high belongs to the packet just granted.
      grant_now = bus.alloc_req & ~gnt_q & any_free;
   end

   // Next-state logic for the per-VC FSMs and credit counters.
   always_comb begin
      for (int v = 0; v < NUM_VC; v++) begin
         cred_d[v]  = cred_q[v];
         state_d[v] = state_q[v];
         // Flit and credit on the same VC cancel out.
         if (flit_acc && (bus.flit_vc == VC_IDX_W'(v)))
            cred_d[v] = cred_d[v] - 1'b1;
         if (cred_acc && (bus.credit_vc == VC_IDX_W'(v)))
            cred_d[v] = cred_d[v] + 1'b1;
         unique case (state_q[v])
            VC_FREE: begin
               if (grant_now && (grant_idx == VC_IDX_W'(v)))
                  state_d[v] = VC_ACTIVE;
            end
            VC_ACTIVE: begin
               if (flit_acc && bus.flit_tail && (bus.flit_vc == VC_IDX_W'(v)))
                  state_d[v] = VC_DRAIN;
            end
            VC_DRAIN: begin
               // Downstream buffer empty once all credits are home, counting one returning now.
               if (cred_d[v] == CRED_MAX)
                  state_d[v] = VC_FREE;
            end
            default: state_d[v] = VC_FREE;
         endcase
      end
      gnt_d    = grant_now;
      gnt_vc_d = grant_now ? grant_idx : gnt_vc_q;
   end

`ifdef VC_ERR_CHECK_EN
   logic flit_drop;
   logic cred_ign;
   always_comb begin
      flit_drop = bus.flit_valid & ~send_ok_w[bus.flit_vc];
      cred_ign  = bus.credit_valid & (cred_q[bus.credit_vc] == CRED_MAX);
      err_d     = flit_drop | cred_ign;
   end
`else
   always_comb begin
      err_d = 1'b0;
   end
`endif

   // State registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int v = 0; v < NUM_VC; v++) begin
            state_q[v] <= VC_FREE;
            cred_q[v]  <= CRED_MAX;
         end
         gnt_q    <= 1'b0;
         gnt_vc_q <= '0;
         err_q    <= 1'b0;
      end else begin
         for (int v = 0; v < NUM_VC; v++) begin
            state_q[v] <= state_d[v];
            cred_q[v]  <= cred_d[v];
         end
         gnt_q    <= gnt_d;
         gnt_vc_q <= gnt_vc_d;
         err_q    <= err_d;
      end
   end

   // Outputs.
   always_comb begin
      bus.vc_busy   = ~free_w;
      bus.send_ok   = send_ok_w;
      bus.alloc_gnt = gnt_q;
      bus.alloc_vc  = gnt_vc_q;
      bus.err       = err_q;
   end

endmodule

// File: tb/tb_vc_status_ctrl.sv
// tb_vc_status_ctrl: scoreboard bench for vc_status_ctrl with a transaction-level reference model.
// Latency: expectations are queued at the driving negedge and checked 1 time unit after the next rising edge.
// Backpressure: the stimulus holds alloc_req until the model reports a grant.
module tb_vc_status_ctrl;

   localparam int NV = 4;
   localparam int BD = 4;

   logic clk;
   logic reset;

   vc_status_ctrl_if #(.NUM_VC(NV), .VC_IDX_W(2)) bus ();

   vc_status_ctrl #(
      .NUM_VC(NV), .VC_IDX_W(2), .BUF_DEPTH(BD), .CNT_W(3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: each VC is a status word plus a count of free downstream slots.
   typedef enum int {M_FREE, M_ACTIVE, M_DRAIN} mst_t;
   mst_t m_st [NV];
   int   m_cr [NV];
   bit   m_gnt;

   typedef struct {
      bit       gnt;
      bit [3:0] busy;
      bit [3:0] sok;
      bit       err;
   } exp_t;

   exp_t exp_q [$];
   int   gnt_q [$];
   int   checks = 0;
   int   errors = 0;
   bit   pend   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   function automatic bit m_sendok(input int v);
      return (m_st[v] == M_ACTIVE) && (m_cr[v] > 0);
   endfunction

   function automatic void model_reset();
      for (int v = 0; v < NV; v++) begin
         m_st[v] = M_FREE;
         m_cr[v] = BD;
      end
      m_gnt = 0;
   endfunction

   // Apply one clock worth of events to the model and queue what the DUT must show after the edge.
   function automatic void model_step(input bit req, input bit fv, input int fvc, input bit ft,
                                      input bit cv, input int cvc);
      mst_t old_st [NV];
      bit   facc, cacc;
      int   g;
      exp_t x;
      old_st = m_st;
      facc = fv && m_sendok(fvc);
      cacc = cv && (m_cr[cvc] < BD);
      if (facc) begin
         m_cr[fvc] = m_cr[fvc] - 1;
         if (ft) m_st[fvc] = M_DRAIN;
      end
      if (cacc) m_cr[cvc] = m_cr[cvc] + 1;
      for (int v = 0; v < NV; v++)
         if (old_st[v] == M_DRAIN && m_cr[v] == BD) m_st[v] = M_FREE;
      g = -1;
      if (req && !m_gnt)
         for (int v = NV - 1; v >= 0; v--)
            if (old_st[v] == M_FREE) g = v;
      m_gnt = (g >= 0);
      if (g >= 0) begin
         m_st[g] = M_ACTIVE;
         gnt_q.push_back(g);
      end
      x.gnt = m_gnt;
      for (int v = 0; v < NV; v++) begin
         x.busy[v] = (m_st[v] != M_FREE);
         x.sok[v]  = m_sendok(v);
      end
      x.err = 1'b0;
`ifdef VC_ERR_CHECK_EN
      x.err = (fv && !facc) || (cv && !cacc);
`endif
      exp_q.push_back(x);
   endfunction

   task automatic drive_idle();
      bus.alloc_req    = 1'b0;
      bus.flit_valid   = 1'b0;
      bus.flit_vc      = 2'd0;
      bus.flit_tail    = 1'b0;
      bus.credit_valid = 1'b0;
      bus.credit_vc    = 2'd0;
   endtask

   task automatic cycle(input bit req, input bit fv, input int fvc, input bit ft,
                        input bit cv, input int cvc);
      @(negedge clk);
      bus.alloc_req    = req;
      bus.flit_valid   = fv;
      bus.flit_vc      = 2'(fvc);
      bus.flit_tail    = ft;
      bus.credit_valid = cv;
      bus.credit_vc    = 2'(cvc);
      model_step(req, fv, fvc, ft, cv, cvc);
   endtask

   task automatic idle();
      cycle(0, 0, 0, 0, 0, 0);
   endtask

   // Assert reset between edges and check that every output clears without waiting for a clock.
   task automatic apply_reset(input string tag);
      reset = 1'b0;
      drive_idle();
      #1;
      chk({tag, "_alloc_gnt"}, bus.alloc_gnt, 0);
      chk({tag, "_alloc_vc"},  bus.alloc_vc,  0);
      chk({tag, "_vc_busy"},   bus.vc_busy,   0);
      chk({tag, "_send_ok"},   bus.send_ok,   0);
      chk({tag, "_err"},       bus.err,       0);
      model_reset();
      exp_q.delete();
      gnt_q.delete();
      pend = 0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic random_cycle();
      int act [$];
      int low [$];
      bit fv, ft, cv;
      int fvc, cvc;
      if (!pend && $urandom_range(0, 3) == 0) pend = 1;
      for (int v = 0; v < NV; v++) begin
         if (m_st[v] == M_ACTIVE) act.push_back(v);
         if (m_cr[v] < BD) low.push_back(v);
      end
      fv = ($urandom_range(0, 1) == 1);
      if (act.size() > 0 && $urandom_range(0, 3) != 0)
         fvc = act[$urandom_range(0, act.size() - 1)];
      else
         fvc = $urandom_range(0, NV - 1);
      ft = ($urandom_range(0, 3) == 0);
      cv = ($urandom_range(0, 2) != 0);
      if (low.size() > 0 && $urandom_range(0, 9) != 0)
         cvc = low[$urandom_range(0, low.size() - 1)];
      else
         cvc = $urandom_range(0, NV - 1);
      cycle(pend, fv, fvc, ft, cv, cvc);
      if (m_gnt) pend = 0;
   endtask

   // Monitor: compare the DUT against the oldest queued expectation; grants pop the grant queue.
   always @(posedge clk) begin
      exp_t x;
      int   g;
      #1;
      if (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         chk("alloc_gnt", bus.alloc_gnt, x.gnt);
         chk("vc_busy",   bus.vc_busy,   x.busy);
         chk("send_ok",   bus.send_ok,   x.sok);
         chk("err",       bus.err,       x.err);
      end
      if (bus.alloc_gnt === 1'b1) begin
         if (gnt_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_grant: got alloc_vc=%0d, expected no grant (t=%0t)", bus.alloc_vc, $time);
         end else begin
            g = gnt_q.pop_front();
            chk("alloc_vc", bus.alloc_vc, g);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation still running, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      drive_idle();
      model_reset();
      #2;
      apply_reset("init_reset");

      // Four grants, one every other edge: VCs 0,1,2,3.
      repeat (8) cycle(1, 0, 0, 0, 0, 0);
      // All busy: the request waits.
      repeat (3) cycle(1, 0, 0, 0, 0, 0);
      // Drain VC2 with the request still held; it is re-granted the edge after it frees.
      for (int i = 0; i < 4; i++) cycle(1, 1, 2, (i == 3), 0, 0);
      for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 1, 2);
      cycle(1, 0, 0, 0, 0, 0);
      idle();

      // Credit exhaustion on VC0, then a dropped fifth flit, then one credit back.
      repeat (4) cycle(0, 1, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 0);
      idle();

      // VC1 down to credit 2, then flit and credit together.
      repeat (2) cycle(0, 1, 1, 0, 0, 0);
      cycle(0, 1, 1, 0, 1, 1);
      idle();

      // Single-flit packet on VC3, credit home frees it.
      cycle(0, 1, 3, 1, 0, 0);
      cycle(0, 0, 0, 0, 1, 3);
      idle();

      // Credits at BUF_DEPTH: VC3 (FREE) and VC2 (ACTIVE, full).
      cycle(0, 0, 0, 0, 1, 3);
      cycle(0, 0, 0, 0, 1, 2);
      idle();

      // Grant VC3 and raise err in the same edge, then reset while both pulses are high.
      cycle(1, 0, 0, 0, 1, 3);
      @(posedge clk);
      #3;
      apply_reset("mid_reset");

      repeat (8) cycle(1, 0, 0, 0, 0, 0);
      idle();

      repeat (1500) random_cycle();
      @(posedge clk);
      #3;
      apply_reset("rand_reset");
      repeat (1500) random_cycle();

      repeat (3) idle();
      @(posedge clk);
      #2;
      chk("exp_queue_drained", exp_q.size(), 0);
      chk("grant_queue_drained", gnt_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
